// File: rtl/lut_ff_mux_bist_pkg.sv
// rtl/lut_ff_mux_bist_pkg.sv - shared types, constants and LFSR step for the lut_ff_mux BIST
package lut_ff_mux_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_e;

   localparam int          DIRECTED_VECS = 5;
   // Taps 16,14,13,11 counted from 1 map to bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED  = 16'hACE1;

   typedef struct packed {
      logic       rst;
      logic [3:0] data;
      logic       sel;
   } stim_vec_t;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic din);
      return {s[14:0], (^(s & LFSR_TAPS)) ^ din};
   endfunction

   function automatic stim_vec_t directed_vec(input logic [2:0] idx);
      stim_vec_t v;
      v = '{rst: 1'b0, data: 4'b0000, sel: 1'b0};
      case (idx)
         3'd0: v = '{rst: 1'b1, data: 4'b0000, sel: 1'b0};
         3'd1: v = '{rst: 1'b0, data: 4'b0100, sel: 1'b0};
         3'd2: v = '{rst: 1'b0, data: 4'b0100, sel: 1'b1};
         3'd3: v = '{rst: 1'b0, data: 4'b0001, sel: 1'b0};
         3'd4: v = '{rst: 1'b0, data: 4'b0001, sel: 1'b1};
         default: v = '{rst: 1'b0, data: 4'b0000, sel: 1'b0};
      endcase
      return v;
   endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// rtl/bist_lfsr16.sv - 16-bit Fibonacci LFSR/MISR with load, advance and serial fold-in
module bist_lfsr16
   import lut_ff_mux_bist_pkg::*;
#(
   parameter logic [15:0] SEED  = DEFAULT_SEED,
   parameter int          OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             advance,
   input  logic             din,
   output logic [OUT_W-1:0] value
);

   logic [15:0] state;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         state <= SEED;
      end else if (advance) begin
         state <= lfsr_step(state, din);
      end
   end

   assign value = state[OUT_W-1:0];

endmodule

// File: rtl/lut_ff_mux_bist.sv
// rtl/lut_ff_mux_bist.sv - BIST sequencer comparing golden and post-route lut_ff_mux copies
// Defining BIST_MISR_EN adds a 16-bit MISR signature of q_golden.
module lut_ff_mux_bist
   import lut_ff_mux_bist_pkg::*;
#(
   parameter int          NUM_RANDOM = 100,
   parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [3:0]  stim_in,
   output logic        stim_rst,
   output logic        stim_mux_sel,
   input  logic        q_golden,
   input  logic        q_dut,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [7:0]  mismatch_cnt,
`ifdef BIST_MISR_EN
   output logic [15:0] signature,
`endif
   output logic [7:0]  vec_idx
);

   // An all-zero seed would lock the LFSR up
   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [8:0]  LAST_IDX = 9'(DIRECTED_VECS + NUM_RANDOM - 1);

   bist_state_e state;
   logic [8:0]  vec_cnt;
   logic [8:0]  next_idx;
   logic [7:0]  mis_cnt;
   logic [3:0]  dir_in;
   logic        dir_sel;
   logic        accept;
   logic        compare;
   logic        last_vec;
   logic        random_phase;
   logic        lfsr_adv;
   logic [2:0]  dv_idx;
   stim_vec_t   dv;
   logic [4:0]  lfsr_bits;

   assign accept       = start && (state == ST_IDLE || state == ST_DONE);
   assign compare      = (state == ST_HOLD);
   assign last_vec     = (vec_cnt == LAST_IDX);
   assign next_idx     = vec_cnt + 9'd1;
   assign random_phase = (vec_cnt >= 9'(DIRECTED_VECS));
   // Advance on the edge that moves onto a random vector so it sees the fresh value
   assign lfsr_adv     = compare && !last_vec && (next_idx >= 9'(DIRECTED_VECS));
   assign dv_idx       = accept ? 3'd0 : next_idx[2:0];
   assign dv           = directed_vec(dv_idx);

   bist_lfsr16 #(
      .SEED  (SEED_EFF),
      .OUT_W (5)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .advance (lfsr_adv),
      .din     (1'b0),
      .value   (lfsr_bits)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         vec_cnt  <= 9'd0;
         mis_cnt  <= 8'd0;
         dir_in   <= 4'd0;
         dir_sel  <= 1'b0;
         stim_rst <= 1'b1;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state    <= ST_APPLY;
                  vec_cnt  <= 9'd0;
                  mis_cnt  <= 8'd0;
                  dir_in   <= dv.data;
                  dir_sel  <= dv.sel;
                  stim_rst <= dv.rst;
               end
            end
            ST_APPLY: state <= ST_HOLD;
            ST_HOLD: begin
               if ((q_golden != q_dut) && (mis_cnt != 8'hFF)) begin
                  mis_cnt <= mis_cnt + 8'd1;
               end
               if (last_vec) begin
                  state <= ST_DONE;
               end else begin
                  state    <= ST_APPLY;
                  vec_cnt  <= next_idx;
                  stim_rst <= 1'b0;
                  if (next_idx < 9'(DIRECTED_VECS)) begin
                     dir_in  <= dv.data;
                     dir_sel <= dv.sel;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign stim_in      = random_phase ? lfsr_bits[3:0] : dir_in;
   assign stim_mux_sel = random_phase ? lfsr_bits[4]   : dir_sel;
   assign busy         = (state == ST_APPLY) || (state == ST_HOLD);
   assign done         = (state == ST_DONE);
   assign pass         = done && (mis_cnt == 8'd0);
   assign mismatch_cnt = mis_cnt;
   assign vec_idx      = vec_cnt[7:0];

`ifdef BIST_MISR_EN
   bist_lfsr16 #(
      .SEED  (16'h0000),
      .OUT_W (16)
   ) u_misr (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .advance (compare),
      .din     (q_golden),
      .value   (signature)
   );
`endif

endmodule

// File: tb/tb_lut_ff_mux_bist.sv
// tb/tb_lut_ff_mux_bist.sv - self-checking bench for lut_ff_mux_bist
module tb_lut_ff_mux_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] din;
      logic       sel;
      logic       srst;
   } vec_t;

   vec_t dir_tbl [5];

   logic       rst_r     [3];
   logic       start_r   [3];
   logic [3:0] stim_in_w [3];
   logic       stim_rst_w[3];
   logic       stim_sel_w[3];
   logic       q_g_w     [3];
   logic       q_d_w     [3];
   logic       busy_w    [3];
   logic       done_w    [3];
   logic       pass_w    [3];
   logic [7:0] cnt_w     [3];
   logic [7:0] idx_w     [3];
   logic       ff_r      [3];
   logic       flip_tbl  [3][256];
`ifdef BIST_MISR_EN
   logic [15:0] sig_w    [3];
`endif

   // Stand-in for the lut_ff_mux copies: a small LUT, a flop behind it, and the output mux
   function automatic logic lut_f(input logic [3:0] x);
      return (x == 4'b0100) || (x == 4'b0001) || (x[3] && x[1]);
   endfunction

   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) ff_r[i] <= stim_rst_w[i] ? 1'b0 : lut_f(stim_in_w[i]);
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         q_g_w[i] = stim_sel_w[i] ? ff_r[i] : lut_f(stim_in_w[i]);
         q_d_w[i] = q_g_w[i] ^ flip_tbl[i][idx_w[i]];
      end
   end

   lut_ff_mux_bist #(.NUM_RANDOM(4)) u_a (
      .clk(clk), .rst(rst_r[0]), .start(start_r[0]), .stim_in(stim_in_w[0]),
      .stim_rst(stim_rst_w[0]), .stim_mux_sel(stim_sel_w[0]), .q_golden(q_g_w[0]),
      .q_dut(q_d_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .mismatch_cnt(cnt_w[0]),
`ifdef BIST_MISR_EN
      .signature(sig_w[0]),
`endif
      .vec_idx(idx_w[0]));

   lut_ff_mux_bist #(.NUM_RANDOM(255)) u_b (
      .clk(clk), .rst(rst_r[1]), .start(start_r[1]), .stim_in(stim_in_w[1]),
      .stim_rst(stim_rst_w[1]), .stim_mux_sel(stim_sel_w[1]), .q_golden(q_g_w[1]),
      .q_dut(q_d_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .mismatch_cnt(cnt_w[1]),
`ifdef BIST_MISR_EN
      .signature(sig_w[1]),
`endif
      .vec_idx(idx_w[1]));

   lut_ff_mux_bist #(.NUM_RANDOM(4), .LFSR_SEED(16'h0000)) u_c (
      .clk(clk), .rst(rst_r[2]), .start(start_r[2]), .stim_in(stim_in_w[2]),
      .stim_rst(stim_rst_w[2]), .stim_mux_sel(stim_sel_w[2]), .q_golden(q_g_w[2]),
      .q_dut(q_d_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
      .mismatch_cnt(cnt_w[2]),
`ifdef BIST_MISR_EN
      .signature(sig_w[2]),
`endif
      .vec_idx(idx_w[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_idle(input int u, input string tag);
      check($sformatf("%s u%0d busy", tag, u), 32'(busy_w[u]), 0);
      check($sformatf("%s u%0d done", tag, u), 32'(done_w[u]), 0);
      check($sformatf("%s u%0d pass", tag, u), 32'(pass_w[u]), 0);
      check($sformatf("%s u%0d mismatch_cnt", tag, u), 32'(cnt_w[u]), 0);
      check($sformatf("%s u%0d vec_idx", tag, u), 32'(idx_w[u]), 0);
      check($sformatf("%s u%0d stim_in", tag, u), 32'(stim_in_w[u]), 0);
      check($sformatf("%s u%0d stim_mux_sel", tag, u), 32'(stim_sel_w[u]), 0);
      check($sformatf("%s u%0d stim_rst", tag, u), 32'(stim_rst_w[u]), 1);
   endtask

   // Pulse start, then follow every cycle of the sequence against the expected vector list
   task automatic run_seq(input int u, input int n, input logic [15:0] seed, input int poke_k);
      int          nv;
      int          exp_cnt;
      int          idx;
      logic [15:0] s;
      logic [3:0]  ein  [260];
      logic        esel [260];
      logic        erst [260];
      nv = 5 + n;
      s = seed;
      exp_cnt = 0;
      for (int v = 0; v < nv; v++) begin
         if (v < 5) begin
            ein[v] = dir_tbl[v].din; esel[v] = dir_tbl[v].sel; erst[v] = dir_tbl[v].srst;
         end else begin
            s = (s << 1) | (((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 16'h0001);
            ein[v] = s[3:0]; esel[v] = s[4]; erst[v] = 1'b0;
         end
         exp_cnt += int'(flip_tbl[u][v % 256]);
      end
      if (exp_cnt > 255) exp_cnt = 255;

      @(negedge clk);
      start_r[u] = 1'b1;
      @(posedge clk);
      #1 start_r[u] = 1'b0;
      for (int k = 0; k < 2 * nv; k++) begin
         @(negedge clk);
         start_r[u] = 1'b0;
         idx = k / 2;
         check($sformatf("u%0d k%0d vec_idx", u, k), 32'(idx_w[u]), 32'(idx % 256));
         check($sformatf("u%0d k%0d stim_in", u, k), 32'(stim_in_w[u]), 32'(ein[idx]));
         check($sformatf("u%0d k%0d stim_mux_sel", u, k), 32'(stim_sel_w[u]), 32'(esel[idx]));
         check($sformatf("u%0d k%0d stim_rst", u, k), 32'(stim_rst_w[u]), 32'(erst[idx]));
         check($sformatf("u%0d k%0d busy", u, k), 32'(busy_w[u]), 1);
         check($sformatf("u%0d k%0d done", u, k), 32'(done_w[u]), 0);
         if (k == poke_k) start_r[u] = 1'b1;
      end
      @(negedge clk);
      start_r[u] = 1'b0;
      check($sformatf("u%0d end done", u), 32'(done_w[u]), 1);
      check($sformatf("u%0d end busy", u), 32'(busy_w[u]), 0);
      check($sformatf("u%0d end mismatch_cnt", u), 32'(cnt_w[u]), 32'(exp_cnt));
      check($sformatf("u%0d end pass", u), 32'(pass_w[u]), 32'(exp_cnt == 0));
      check($sformatf("u%0d end stim_in held", u), 32'(stim_in_w[u]), 32'(ein[nv-1]));
      check($sformatf("u%0d end stim_sel held", u), 32'(stim_sel_w[u]), 32'(esel[nv-1]));
   endtask

   task automatic set_flips(input int u, input int mode);
      for (int j = 0; j < 256; j++)
         flip_tbl[u][j] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
   endtask

   initial begin
      dir_tbl[0] = '{din: 4'b0000, sel: 1'b0, srst: 1'b1};
      dir_tbl[1] = '{din: 4'b0100, sel: 1'b0, srst: 1'b0};
      dir_tbl[2] = '{din: 4'b0100, sel: 1'b1, srst: 1'b0};
      dir_tbl[3] = '{din: 4'b0001, sel: 1'b0, srst: 1'b0};
      dir_tbl[4] = '{din: 4'b0001, sel: 1'b1, srst: 1'b0};
      for (int u = 0; u < 3; u++) begin
         rst_r[u] = 1'b1;
         start_r[u] = 1'b0;
         set_flips(u, 0);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 3; u++) check_idle(u, "reset");
      for (int u = 0; u < 3; u++) rst_r[u] = 1'b0;
      repeat (2) @(negedge clk);
      for (int u = 0; u < 3; u++) check_idle(u, "idle");

      // Matching copies: clean pass, then results must stay put in DONE
      run_seq(0, 4, 16'hACE1, -1);
      repeat (5) @(negedge clk);
      check("done stable done", 32'(done_w[0]), 1);
      check("done stable pass", 32'(pass_w[0]), 1);
      check("done stable cnt", 32'(cnt_w[0]), 0);

      // Inverted q_dut restarted straight from DONE
      set_flips(0, 1);
      run_seq(0, 4, 16'hACE1, -1);

      for (int r = 0; r < 3; r++) begin
         set_flips(0, 2);
         run_seq(0, 4, 16'hACE1, -1);
      end

      // start during APPLY must be ignored
      set_flips(0, 0);
      run_seq(0, 4, 16'hACE1, 4);

      // Abort at vec_idx 3 with mismatches already counted
      set_flips(0, 1);
      @(negedge clk);
      start_r[0] = 1'b1;
      @(posedge clk);
      #1 start_r[0] = 1'b0;
      for (int t = 0; t < 40 && idx_w[0] != 8'd3; t++) @(negedge clk);
      check("abort reached vec 3", 32'(idx_w[0]), 3);
      rst_r[0] = 1'b1;
      @(posedge clk);
      #1 rst_r[0] = 1'b0;
      @(negedge clk);
      check_idle(0, "abort");
      run_seq(0, 4, 16'hACE1, -1);

      // Saturation with 260 mismatching vectors
      set_flips(1, 1);
      run_seq(1, 255, 16'hACE1, -1);

      // Zero seed behaves as 0001; start during HOLD ignored
      run_seq(2, 4, 16'h0001, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
